// File: rtl/lstm_seq_ctrl_pkg.sv
// lstm_seq_ctrl_pkg
// Shared constants and types for the LSTM sequence controller:
//   - default array_bp-side parameters (address width, timesteps,
//     compute latency, target-memory depth)
//   - FSM state encoding
//   - step-counter width helper
//   - strobe bundle type and the state -> strobe decode
package lstm_seq_ctrl_pkg;

  // array_bp-side defaults
  localparam int LSTM_ADDR_W         = 32;
  localparam int LSTM_NUM_ITER       = 8;
  localparam int LSTM_COMPUTE_CYCLES = 43;
  localparam int LSTM_ADDR_DEPTH     = 16;

  // Step index must hold 0..NUM_ITERATIONS-1 with one bit of headroom
  function automatic int lstm_step_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int LSTM_STEP_W = lstm_step_w(LSTM_NUM_ITER);

  // FSM encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_TLOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd3;
  localparam logic [STATE_W-1:0] ST_HUPD  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic load_t;
    logic load_in;
    logic load_bp;
    logic load_h;
  } lstm_strobe_t;

  // At most one strobe group is active for any state
  function automatic lstm_strobe_t lstm_decode_strobes(input logic [STATE_W-1:0] st);
    lstm_strobe_t s;
    s = '0;
    case (st)
      ST_TLOAD: s.load_t = 1'b1;
      ST_LOAD: begin
        s.load_in = 1'b1;
        s.load_bp = 1'b1;
      end
      ST_HUPD:  s.load_h = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lstm_seq_cnt.sv
// lstm_seq_cnt
// Loadable down-counter with a terminal-count flag. Loading value V gives
// V+1 cycles until tc (tc is high while the count is zero).
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   load_i   load val_i into the counter (takes priority over en_i)
//   en_i     decrement enable; the count saturates at zero
//   val_i    load value
//   tc_o     terminal count, high while the count is zero
module lstm_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl
// Sequences one LSTM run on array_bp: load NUM_ITERATIONS targets, then per
// timestep wait COMPUTE_CYCLES, load input/backprop registers, update the
// hidden state. Pulses done at the end and advances the target base address.
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   start     start request, honoured only in IDLE
//   abort     synchronous abort back to IDLE
//   sel       h-feedback select (0 = zero initial state)
//   load_in   input register load strobe
//   load_bp   backprop register load strobe
//   load_h    hidden-state update strobe
//   load_t    target-memory write strobe
//   o_addr_t  target-memory address
//   o_step    current timestep index
//   busy      high outside IDLE
//   done      one-cycle end-of-sequence pulse
// All outputs come straight from flops.
module lstm_seq_ctrl
  import lstm_seq_ctrl_pkg::*;
#(
  parameter int WIDTH          = LSTM_ADDR_W,
  parameter int NUM_ITERATIONS = LSTM_NUM_ITER,
  parameter int COMPUTE_CYCLES = LSTM_COMPUTE_CYCLES,
  parameter int ADDR_DEPTH     = LSTM_ADDR_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            sel,
  output logic                            load_in,
  output logic                            load_bp,
  output logic                            load_h,
  output logic                            load_t,
  output logic [WIDTH-1:0]                o_addr_t,
  output logic [$clog2(NUM_ITERATIONS):0] o_step,
  output logic                            busy,
  output logic                            done
);

  localparam int STEP_W  = lstm_step_w(NUM_ITERATIONS);
  localparam int CNT_MAX = (NUM_ITERATIONS > COMPUTE_CYCLES) ? NUM_ITERATIONS : COMPUTE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter is loaded with length-1 so that tc marks the last cycle
  localparam logic [CNT_W-1:0]  TLOAD_LEN = CNT_W'(NUM_ITERATIONS - 1);
  localparam logic [CNT_W-1:0]  WAIT_LEN  = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_ITERATIONS - 1);
  localparam logic [WIDTH-1:0]  DEPTH_M1  = WIDTH'(ADDR_DEPTH - 1);
  localparam logic [WIDTH:0]    DEPTH_X   = (WIDTH+1)'(ADDR_DEPTH);
  localparam logic [WIDTH:0]    BASE_INC  = (WIDTH+1)'(NUM_ITERATIONS % ADDR_DEPTH);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic               sel_q, sel_d;
  lstm_strobe_t       strobe_q;
  logic               busy_q, done_q;

  logic               cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   cnt_val;

  logic [WIDTH-1:0]   addr_inc;
  logic [WIDTH:0]     base_sum;
  logic [WIDTH-1:0]   base_adv;

  // Modular arithmetic without a divider: address and base stay < ADDR_DEPTH
  assign addr_inc = (addr_q == DEPTH_M1) ? '0 : addr_q + WIDTH'(1);
  assign base_sum = {1'b0, base_q} + BASE_INC;
  assign base_adv = (base_sum >= DEPTH_X) ? WIDTH'(base_sum - DEPTH_X) : base_sum[WIDTH-1:0];

  lstm_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (cnt_val),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    addr_d   = addr_q;
    base_d   = base_q;
    sel_d    = sel_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;

    if (abort && (state_q != ST_IDLE)) begin
      // Abort wins over everything; the base is left untouched
      state_d = ST_IDLE;
      step_d  = '0;
      sel_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_TLOAD;
            step_d   = '0;
            sel_d    = 1'b0;
            addr_d   = base_q;
            cnt_load = 1'b1;
            cnt_val  = TLOAD_LEN;
          end
        end
        ST_TLOAD: begin
          if (cnt_tc) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
            cnt_val  = WAIT_LEN;
          end else begin
            cnt_en = 1'b1;
            addr_d = addr_inc;
          end
        end
        ST_WAIT: begin
          if (cnt_tc) begin
            state_d = ST_LOAD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_LOAD: state_d = ST_HUPD;
        ST_HUPD: begin
          // After the first hidden-state update, feedback uses real h
          sel_d = 1'b1;
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            base_d  = base_adv;
          end else begin
            state_d  = ST_WAIT;
            step_d   = step_q + STEP_W'(1);
            cnt_load = 1'b1;
            cnt_val  = WAIT_LEN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          step_d  = '0;
          sel_d   = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
          sel_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      sel_q    <= 1'b0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      sel_q    <= sel_d;
      // Strobes are registered from the next state so they align with it
      strobe_q <= lstm_decode_strobes(state_d);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign sel      = sel_q;
  assign load_t   = strobe_q.load_t;
  assign load_in  = strobe_q.load_in;
  assign load_bp  = strobe_q.load_bp;
  assign load_h   = strobe_q.load_h;
  assign o_addr_t = addr_q;
  assign o_step   = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl
// Directed bench for lstm_seq_ctrl at default parameters. Expected target
// addresses and done cycles are queued when a start is driven and checked
// as the DUT produces load_t / done.
module tb_lstm_seq_ctrl;

  localparam int N     = 8;
  localparam int C     = 43;
  localparam int D     = 16;
  localparam int TOTAL = N + N * (C + 2) + 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sel;
  logic        load_in;
  logic        load_bp;
  logic        load_h;
  logic        load_t;
  logic [31:0] o_addr_t;
  logic [3:0]  o_step;
  logic        busy;
  logic        done;

  lstm_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .sel      (sel),
    .load_in  (load_in),
    .load_bp  (load_bp),
    .load_h   (load_h),
    .load_t   (load_t),
    .o_addr_t (o_addr_t),
    .o_step   (o_step),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  logic [31:0] cyc;
  int          tb_base;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_done[$];
  logic [31:0] mark;
  bit          ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and per-cycle invariants, sampled 1 time unit after each edge
  task automatic monitor();
    logic [31:0] e;
    if (load_t) begin
      chk("addr_expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) begin
        e = exp_addr.pop_front();
        chk("addr_t", o_addr_t, e);
      end
    end
    if (done) begin
      chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
      if (exp_done.size() > 0) begin
        e = exp_done.pop_front();
        chk("done_cycle", cyc, e);
      end
    end
    chk("strobe_excl", 32'($countones({load_t, load_in, load_h}) <= 1), 32'd1);
    chk("in_eq_bp", 32'(load_in), 32'(load_bp));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc = cyc + 32'd1;
      #1;
      monitor();
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return load_in;
      1:       return done;
      2:       return load_h && (o_step == 4'd2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input string tag, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (cond(which)) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    for (int k = 0; k < N; k++) exp_addr.push_back(32'((tb_base + k) % D));
    exp_done.push_back(cyc + 32'(TOTAL));
    step(1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_strobes"}, 32'({load_t, load_in, load_bp, load_h}), 32'd0);
    chk({tag, "_step"}, 32'(o_step), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = '0;
    tb_base     = 0;
    rst         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;

    // Reset values before any clock edge
    #2;
    chk_idle_outputs("rst");
    chk("rst_addr", o_addr_t, 32'd0);
    step(2);
    rst = 1'b1;
    step(2);

    // Run 1: start sampled at cycle 5
    mark = cyc;
    do_start(1'b0);
    chk("r1_busy", 32'(busy), 32'd1);
    chk("r1_load_t", 32'(load_t), 32'd1);
    chk("r1_step0", 32'(o_step), 32'd0);
    chk("r1_sel_tload", 32'(sel), 32'd0);
    wait_until(0, "r1_load_in_seen", ok);
    chk("r1_load_in_cycle", cyc, mark + 32'(1 + N + C));
    step(1);
    chk("r1_h0_load_h", 32'(load_h), 32'd1);
    chk("r1_h0_sel", 32'(sel), 32'd0);
    step(1);
    chk("r1_w1_sel", 32'(sel), 32'd1);
    chk("r1_w1_step", 32'(o_step), 32'd1);
    step(C + 1);
    chk("r1_h1_load_h", 32'(load_h), 32'd1);
    chk("r1_h1_sel", 32'(sel), 32'd1);
    wait_until(1, "r1_done_seen", ok);
    chk("r1_done_sel", 32'(sel), 32'd1);
    step(1);
    chk_idle_outputs("r1_after");
    tb_base = (tb_base + N) % D;

    // Run 2 back-to-back: addresses 8..15
    do_start(1'b0);
    wait_until(1, "r2_done_seen", ok);
    tb_base = (tb_base + N) % D;
    step(1);

    // Run 3: addresses wrap to 0..7; starts during WAIT and at done ignored
    do_start(1'b0);
    step(20);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("r3_wait_start_busy", 32'(busy), 32'd1);
    chk("r3_wait_start_step", 32'(o_step), 32'd0);
    chk("r3_wait_start_no_t", 32'(load_t), 32'd0);
    wait_until(1, "r3_done_seen", ok);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("r3_busy_fall", 32'(busy), 32'd0);
    step(3);
    chk_idle_outputs("r3_no_restart");
    tb_base = (tb_base + N) % D;

    // Run 4: asynchronous reset in the middle of LOAD
    do_start(1'b0);
    wait_until(0, "r4_load_in_seen", ok);
    #3;
    rst = 1'b0;
    #1;
    chk_idle_outputs("r4_async_rst");
    chk("r4_rst_load_in", 32'(load_in), 32'd0);
    chk("r4_rst_addr", o_addr_t, 32'd0);
    exp_addr.delete();
    exp_done.delete();
    tb_base = 0;
    step(1);
    rst = 1'b1;
    step(1);

    // Run 5: abort during step-3 WAIT
    do_start(1'b0);
    wait_until(2, "r5_h2_seen", ok);
    step(1);
    chk("r5_wait3_step", 32'(o_step), 32'd3);
    step(5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    exp_done.delete();
    chk_idle_outputs("r5_abort");
    step(4);
    chk_idle_outputs("r5_abort_hold");

    // Run 6: abort in IDLE coincident with start has no effect; base still 0
    do_start(1'b1);
    chk("r6_busy", 32'(busy), 32'd1);
    chk("r6_load_t", 32'(load_t), 32'd1);
    wait_until(1, "r6_done_seen", ok);
    step(2);
    chk_idle_outputs("r6_after");

    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
